retro_memory_port_arbiter: RTL

RETRO_MEMORY_PORT_ARBITER -- requirements
Module: retro_memory_port_arbiter

---
 rtl/retro_memory_port_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/retro_memory_port_arbiter.sv
// Round-robin arbiter sharing one memory target port among several initiators,
// with an in-order read-tag FIFO that steers returned read data to its requester.
module retro_memory_port_arbiter #(
    parameter int Channels        = 2,
    parameter int AddressBusWidth = 16,
    parameter int DataBusWidth    = 8,
    parameter int MaxOutstanding  = 4
) (
    input  logic                                    Clk,
    input  logic                                    Reset,
    input  logic [Channels*AddressBusWidth-1:0]     InAddress,
    input  logic [Channels*DataBusWidth-1:0]        InDout,
    input  logic [Channels-1:0]                     InAccess,
    input  logic [Channels-1:0]                     InWrite,
    output logic [Channels-1:0]                     InReady,
    output logic [DataBusWidth-1:0]                 InDin,
    output logic [Channels-1:0]                     InDataReady,
    output logic [AddressBusWidth-1:0]              Address,
    output logic [DataBusWidth-1:0]                 Dout,
    output logic                                    Access,
    output logic                                    Write,
    input  logic                                    Ready,
    input  logic                                    DataReady,
    input  logic [DataBusWidth-1:0]                 Din,
    output logic [$clog2(MaxOutstanding+1)-1:0]     Outstanding,
    output logic                                    Underflow
);

    localparam int ChW = $clog2(Channels);
    localparam int FW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CW  = $clog2(MaxOutstanding + 1);

    logic [ChW-1:0] rr_ptr_r;
    logic [ChW-1:0] tag_mem_r [MaxOutstanding];
    logic [FW-1:0]  rd_ptr_r;
    logic [FW-1:0]  wr_ptr_r;
    logic [CW-1:0]  count_r;
    logic           underflow_r;

    logic [Channels-1:0] eligible_s;
    logic [ChW-1:0]      grant_s;
    logic [ChW-1:0]      head_s;
    logic                any_s;
    logic                access_s;
    logic                accept_s;
    logic                push_s;
    logic                pop_s;
    logic                full_s;

    // Pointer advance that wraps at the FIFO depth, so any depth works.
    function automatic logic [FW-1:0] fifo_next(input logic [FW-1:0] ptr);
        fifo_next = (ptr == FW'(MaxOutstanding - 1)) ? {FW{1'b0}} : ptr + FW'(1);
    endfunction

    assign full_s   = (count_r == CW'(MaxOutstanding));
    assign pop_s    = DataReady & (count_r != {CW{1'b0}}) & ~Reset;
    assign head_s   = tag_mem_r[rd_ptr_r];
    // A pop in the same cycle frees a slot, so a read may still go out when full.
    assign eligible_s = InAccess & (InWrite | {Channels{~full_s | pop_s}});

    // Round-robin search upward from rr_ptr_r; the lowest offset found wins.
    always_comb begin
        int idx_v;
        grant_s = {ChW{1'b0}};
        any_s   = 1'b0;
        idx_v   = 0;
        for (int k = Channels - 1; k >= 0; k--) begin
            idx_v   = int'(rr_ptr_r) + k;
            idx_v   = (idx_v >= Channels) ? idx_v - Channels : idx_v;
            grant_s = eligible_s[idx_v] ? ChW'(idx_v) : grant_s;
            any_s   = any_s | eligible_s[idx_v];
        end
    end

    assign access_s = any_s & ~Reset;
    assign accept_s = access_s & Ready;
    assign push_s   = accept_s & ~InWrite[grant_s];

    // Target-side command mux and per-channel handshake/return decode.
    always_comb begin
        Address     = InAddress[int'(grant_s)*AddressBusWidth +: AddressBusWidth];
        Dout        = InDout[int'(grant_s)*DataBusWidth +: DataBusWidth];
        Access      = access_s;
        Write       = access_s & InWrite[grant_s];
        InDin       = Din;
        InReady     = {Channels{1'b0}};
        InDataReady = {Channels{1'b0}};
        for (int i = 0; i < Channels; i++) begin
            InReady[i]     = accept_s & (grant_s == ChW'(i));
            InDataReady[i] = pop_s & (head_s == ChW'(i));
        end
    end

    assign Outstanding = count_r;
    assign Underflow   = underflow_r;

    // Tag storage: written on every accepted read, no reset needed.
    always_ff @(posedge Clk) begin
        if (push_s) begin
            tag_mem_r[wr_ptr_r] <= grant_s;
        end else begin
            tag_mem_r[wr_ptr_r] <= tag_mem_r[wr_ptr_r];
        end
    end

    // Arbitration pointer, FIFO pointers, occupancy and sticky underflow.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rr_ptr_r    <= {ChW{1'b0}};
            rd_ptr_r    <= {FW{1'b0}};
            wr_ptr_r    <= {FW{1'b0}};
            count_r     <= {CW{1'b0}};
            underflow_r <= 1'b0;
        end else begin
            if (accept_s) begin
                rr_ptr_r <= (grant_s == ChW'(Channels - 1)) ? {ChW{1'b0}} : grant_s + ChW'(1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            wr_ptr_r <= push_s ? fifo_next(wr_ptr_r) : wr_ptr_r;
            rd_ptr_r <= pop_s ? fifo_next(rd_ptr_r) : rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            underflow_r <= underflow_r | (DataReady & (count_r == {CW{1'b0}}));
        end
    end

endmodule
